// File: rtl/calc_pkg.sv
// Shared constants for the calculator keypad-entry sequencer: ALU operator codes,
// FSM state codes, display-select codes and button indices.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_OP_SET  = 3'd1;
  localparam logic [2:0] ST_ENTER_B = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_RES = 2'd2;

  localparam int BTN_NEG = 0;
  localparam int BTN_ADD = 1;
  localparam int BTN_SUB = 2;
  localparam int BTN_MUL = 3;
  localparam int BTN_DIV = 4;
  localparam int BTN_MOD = 5;
  localparam int BTN_CLR = 6;
  localparam int BTN_EQU = 7;

  // Operator buttons ADD..MOD sit one index above their ALU codes.
  function automatic logic [2:0] btn_to_op(input logic [2:0] code);
    return code - 3'd1;
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Request/acknowledge channel between the entry sequencer (master) and the ALU (slave).
interface calc_entry_ctrl_if #(parameter int W = 32);
  logic         alu_req;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_ack;
  logic [W-1:0] alu_result;
  logic         alu_err;

  modport master (output alu_req, alu_op, alu_a, alu_b,
                  input  alu_ack, alu_result, alu_err);
  modport slave  (input  alu_req, alu_op, alu_a, alu_b,
                  output alu_ack, alu_result, alu_err);
endinterface

// File: rtl/calc_btn_edge.sv
// Rising-edge detection on the level buttons, reduced to at most one key event per cycle.
module calc_btn_edge
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] btn_digit,
  input  logic [7:0] btn_op,
  output logic       key_vld,
  output logic       key_is_digit,
  output logic [3:0] key_code
);

  logic [9:0] dig_prev_q, dig_prev_d;
  logic [7:0] op_prev_q, op_prev_d;
  logic [9:0] dig_rise;
  logic [7:0] op_rise;

  assign dig_prev_d = btn_digit;
  assign op_prev_d  = btn_op;
  assign dig_rise   = btn_digit & ~dig_prev_q;
  assign op_rise    = btn_op & ~op_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_prev_q <= '0;
      op_prev_q  <= '0;
    end else begin
      dig_prev_q <= dig_prev_d;
      op_prev_q  <= op_prev_d;
    end
  end

  // Later assignments win, so each pass overrides the lower-priority ones.
  always_comb begin
    key_vld      = 1'b0;
    key_is_digit = 1'b0;
    key_code     = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (dig_rise[i]) begin
        key_vld      = 1'b1;
        key_is_digit = 1'b1;
        key_code     = 4'(i);
      end
    end
    for (int i = BTN_MOD; i >= BTN_NEG; i--) begin
      if (op_rise[i]) begin
        key_vld      = 1'b1;
        key_is_digit = 1'b0;
        key_code     = 4'(i);
      end
    end
    if (op_rise[BTN_EQU]) begin
      key_vld      = 1'b1;
      key_is_digit = 1'b0;
      key_code     = 4'(BTN_EQU);
    end
    if (op_rise[BTN_CLR]) begin
      key_vld      = 1'b1;
      key_is_digit = 1'b0;
      key_code     = 4'(BTN_CLR);
    end
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-entry sequencer: builds two signed decimal operands and an operator,
// issues them to the ALU over req/ack and holds the result for display.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            btn_digit,
  input  logic [7:0]            btn_op,
  calc_entry_ctrl_if.master     alu,
  output logic [W-1:0]          disp_val,
  output logic [1:0]            disp_sel,
  output logic [2:0]            state_o,
  output logic                  err
);

  localparam int CW = $clog2(DIGITS + 1);

  logic          key_vld, key_is_digit;
  logic [3:0]    key_code;
  logic          is_dig, is_neg, is_op, is_clr, is_equ, do_clear;
  logic [W-1:0]  dig_ext, a_val, b_val;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  a_mag_q, a_mag_d, b_mag_q, b_mag_d, res_q, res_d;
  logic          a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [2:0]    op_q, op_d;
  logic          err_q, err_d, clr_pend_q, clr_pend_d;

  calc_btn_edge u_btn_edge (
    .clk          (clk),
    .rst          (rst),
    .btn_digit    (btn_digit),
    .btn_op       (btn_op),
    .key_vld      (key_vld),
    .key_is_digit (key_is_digit),
    .key_code     (key_code)
  );

  assign is_dig  = key_vld && key_is_digit;
  assign is_neg  = key_vld && !key_is_digit && (key_code == 4'(BTN_NEG));
  assign is_op   = key_vld && !key_is_digit && (key_code >= 4'(BTN_ADD)) && (key_code <= 4'(BTN_MOD));
  assign is_clr  = key_vld && !key_is_digit && (key_code == 4'(BTN_CLR));
  assign is_equ  = key_vld && !key_is_digit && (key_code == 4'(BTN_EQU));
  assign dig_ext = W'(key_code);
  assign a_val   = a_neg_q ? -a_mag_q : a_mag_q;
  assign b_val   = b_neg_q ? -b_mag_q : b_mag_q;

  always_comb begin
    state_d    = state_q;
    a_mag_d    = a_mag_q;
    a_neg_d    = a_neg_q;
    a_cnt_d    = a_cnt_q;
    b_mag_d    = b_mag_q;
    b_neg_d    = b_neg_q;
    b_cnt_d    = b_cnt_q;
    op_d       = op_q;
    res_d      = res_q;
    err_d      = err_q;
    clr_pend_d = clr_pend_q;
    do_clear   = 1'b0;
    case (state_q)
      ST_ENTER_A: begin
        if (is_dig) begin
          if (a_cnt_q < CW'(DIGITS)) begin
            a_mag_d = a_mag_q * W'(10) + dig_ext;
            a_cnt_d = a_cnt_q + 1'b1;
          end
        end else if (is_neg) begin
          a_neg_d = ~a_neg_q;
        end else if (is_op) begin
          op_d    = btn_to_op(key_code[2:0]);
          state_d = ST_OP_SET;
        end
      end
      ST_OP_SET: begin
        if (is_dig || is_neg) begin
          b_mag_d = is_dig ? dig_ext : '0;
          b_neg_d = is_neg;
          b_cnt_d = is_dig ? CW'(1) : '0;
          state_d = ST_ENTER_B;
        end else if (is_op) begin
          op_d = btn_to_op(key_code[2:0]);
        end
      end
      ST_ENTER_B: begin
        if (is_dig) begin
          if (b_cnt_q < CW'(DIGITS)) begin
            b_mag_d = b_mag_q * W'(10) + dig_ext;
            b_cnt_d = b_cnt_q + 1'b1;
          end
        end else if (is_neg) begin
          b_neg_d = ~b_neg_q;
        end else if (is_equ) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A CLR seen while waiting is held until the ALU answers; that answer is dropped.
        if (alu.alu_ack) begin
          if (clr_pend_q || is_clr) begin
            do_clear = 1'b1;
          end else if (alu.alu_err) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            res_d   = alu.alu_result;
            state_d = ST_DONE;
          end
        end else if (is_clr) begin
          clr_pend_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (is_op) begin
          a_mag_d = res_q[W-1] ? -res_q : res_q;
          a_neg_d = res_q[W-1];
          a_cnt_d = CW'(DIGITS);
          op_d    = btn_to_op(key_code[2:0]);
          state_d = ST_OP_SET;
        end else if (is_dig || is_neg) begin
          a_mag_d = is_dig ? dig_ext : '0;
          a_neg_d = is_neg;
          a_cnt_d = is_dig ? CW'(1) : '0;
          state_d = ST_ENTER_A;
        end
      end
      ST_ERROR: ;
      default: state_d = ST_ENTER_A;
    endcase
    if (do_clear || (is_clr && state_q != ST_ISSUE)) begin
      state_d    = ST_ENTER_A;
      a_mag_d    = '0;
      a_neg_d    = 1'b0;
      a_cnt_d    = '0;
      b_mag_d    = '0;
      b_neg_d    = 1'b0;
      b_cnt_d    = '0;
      op_d       = OP_ADD;
      res_d      = '0;
      err_d      = 1'b0;
      clr_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ENTER_A;
      a_mag_q    <= '0;
      a_neg_q    <= 1'b0;
      a_cnt_q    <= '0;
      b_mag_q    <= '0;
      b_neg_q    <= 1'b0;
      b_cnt_q    <= '0;
      op_q       <= OP_ADD;
      res_q      <= '0;
      err_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_mag_q    <= a_mag_d;
      a_neg_q    <= a_neg_d;
      a_cnt_q    <= a_cnt_d;
      b_mag_q    <= b_mag_d;
      b_neg_q    <= b_neg_d;
      b_cnt_q    <= b_cnt_d;
      op_q       <= op_d;
      res_q      <= res_d;
      err_q      <= err_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // Request is a pure state decode so an asynchronous reset drops it at once.
  assign alu.alu_req = (state_q == ST_ISSUE);
  assign alu.alu_op  = op_q;
  assign alu.alu_a   = a_val;
  assign alu.alu_b   = b_val;
  assign state_o     = state_q;
  assign err         = err_q;

  always_comb begin
    disp_sel = SEL_A;
    disp_val = a_val;
    case (state_q)
      ST_ENTER_B, ST_ISSUE: begin
        disp_sel = SEL_B;
        disp_val = b_val;
      end
      ST_DONE: begin
        disp_sel = SEL_RES;
        disp_val = res_q;
      end
      ST_ERROR: begin
        disp_sel = SEL_RES;
        disp_val = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed keypad scenarios with literal expectations, then
// random button/ack traffic, all checked every cycle against a behavioural calculator model.
module tb_calc_entry_ctrl;

  localparam int S_EA = 0, S_OS = 1, S_EB = 2, S_IS = 3, S_DN = 4, S_ER = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  bd;
  logic [7:0]  bo;
  logic        ack, aerr;
  logic [31:0] ares;
  logic [31:0] disp_val;
  logic [1:0]  disp_sel;
  logic [2:0]  state_o;
  logic        err;
  bit          chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  calc_entry_ctrl_if #(.W(32)) alu_if ();
  assign alu_if.alu_ack    = ack;
  assign alu_if.alu_result = ares;
  assign alu_if.alu_err    = aerr;

  calc_entry_ctrl #(.DIGITS(4), .W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_digit (bd),
    .btn_op    (bo),
    .alu       (alu_if),
    .disp_val  (disp_val),
    .disp_sel  (disp_sel),
    .state_o   (state_o),
    .err       (err)
  );

  always #5 clk = ~clk;

  // calculator model
  int m_st, m_amag, m_aneg, m_acnt, m_bmag, m_bneg, m_bcnt, m_op, m_res, m_err, m_pend;
  bit [9:0] m_pd;
  bit [7:0] m_po;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    m_st = S_EA; m_amag = 0; m_aneg = 0; m_acnt = 0; m_bmag = 0; m_bneg = 0; m_bcnt = 0;
    m_op = 0; m_res = 0; m_err = 0; m_pend = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_pd = '0;
    m_po = '0;
  endfunction

  function automatic void model_step();
    bit [9:0] rd;
    bit [7:0] ro;
    int ev;
    bit isdig, isneg, isop, clr, equ;
    rd = bd & ~m_pd;
    ro = bo & ~m_po;
    m_pd = bd;
    m_po = bo;
    ev = -1;
    if (ro[6]) ev = 16;
    else if (ro[7]) ev = 17;
    else begin
      for (int i = 5; i >= 0; i--) if (ro[i]) ev = 10 + i;
      if (ev < 0) for (int i = 9; i >= 0; i--) if (rd[i]) ev = i;
    end
    isdig = (ev >= 0 && ev < 10);
    isneg = (ev == 10);
    isop  = (ev >= 11 && ev <= 15);
    clr   = (ev == 16);
    equ   = (ev == 17);
    if (m_st == S_IS) begin
      if (ack) begin
        if (m_pend != 0 || clr) model_clear();
        else if (aerr) begin m_err = 1; m_st = S_ER; end
        else begin m_res = int'(ares); m_st = S_DN; end
      end else if (clr) m_pend = 1;
    end else if (clr) model_clear();
    else begin
      case (m_st)
        S_EA: begin
          if (isdig) begin
            if (m_acnt < 4) begin m_amag = m_amag * 10 + ev; m_acnt++; end
          end else if (isneg) m_aneg ^= 1;
          else if (isop) begin m_op = ev - 11; m_st = S_OS; end
        end
        S_OS: begin
          if (isdig) begin m_bmag = ev; m_bneg = 0; m_bcnt = 1; m_st = S_EB; end
          else if (isneg) begin m_bmag = 0; m_bneg = 1; m_bcnt = 0; m_st = S_EB; end
          else if (isop) m_op = ev - 11;
        end
        S_EB: begin
          if (isdig) begin
            if (m_bcnt < 4) begin m_bmag = m_bmag * 10 + ev; m_bcnt++; end
          end else if (isneg) m_bneg ^= 1;
          else if (equ) m_st = S_IS;
        end
        S_DN: begin
          if (isop) begin
            m_amag = (m_res < 0) ? -m_res : m_res;
            m_aneg = (m_res < 0);
            m_acnt = 4;
            m_op = ev - 11;
            m_st = S_OS;
          end else if (isdig) begin m_amag = ev; m_aneg = 0; m_acnt = 1; m_st = S_EA; end
          else if (isneg) begin m_amag = 0; m_aneg = 1; m_acnt = 0; m_st = S_EA; end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic int val_a(); return (m_aneg != 0) ? -m_amag : m_amag; endfunction
  function automatic int val_b(); return (m_bneg != 0) ? -m_bmag : m_bmag; endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int ev_val, ev_sel;
      case (m_st)
        S_EA, S_OS: begin ev_val = val_a(); ev_sel = 0; end
        S_EB, S_IS: begin ev_val = val_b(); ev_sel = 1; end
        S_DN:       begin ev_val = m_res;   ev_sel = 2; end
        default:    begin ev_val = 0;       ev_sel = 2; end
      endcase
      chk("state_o", state_o, m_st);
      chk("alu_req", alu_if.alu_req, (m_st == S_IS) ? 1 : 0);
      chk("alu_op", alu_if.alu_op, m_op);
      chk("alu_a", $signed(alu_if.alu_a), val_a());
      chk("alu_b", $signed(alu_if.alu_b), val_b());
      chk("disp_val", $signed(disp_val), ev_val);
      chk("disp_sel", disp_sel, ev_sel);
      chk("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic press_dig(int d);
    bd[d] = 1'b1; tick(); bd[d] = 1'b0; tick();
  endtask

  task automatic press_op(int i);
    bo[i] = 1'b1; tick(); bo[i] = 1'b0; tick();
  endtask

  task automatic do_ack(int r, bit e);
    ack = 1'b1; ares = 32'(r); aerr = e; tick(); ack = 1'b0; aerr = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; bd = '0; bo = '0; ack = 1'b0; aerr = 1'b0; ares = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset state", state_o, 0);
    chk("reset disp_val", disp_val, 0);
    chk("reset req", alu_if.alu_req, 0);

    // 23 * -456
    press_dig(2); press_dig(3); press_op(3); press_op(0);
    press_dig(4); press_dig(5); press_dig(6); press_op(7);
    chk("mul req", alu_if.alu_req, 1);
    chk("mul a", $signed(alu_if.alu_a), 23);
    chk("mul b", $signed(alu_if.alu_b), -456);
    chk("mul op", alu_if.alu_op, 2);
    do_ack(-10488, 1'b0);
    chk("mul disp", $signed(disp_val), -10488);
    chk("mul sel", disp_sel, 2);
    chk("mul state", state_o, S_DN);

    // digit limit and held button
    press_op(6);
    for (int d = 1; d <= 5; d++) press_dig(d);
    chk("limit disp", disp_val, 1234);
    bd[7] = 1'b1; repeat (1000) tick();
    chk("hold7 limit", disp_val, 1234);
    bd[7] = 1'b0; tick();
    press_op(6);
    bd[7] = 1'b1; repeat (50) tick();
    chk("hold7 once", disp_val, 7);
    bd[7] = 1'b0; tick();

    // divide-by-zero
    press_op(6); press_dig(9); press_op(4); press_dig(0); press_op(7);
    do_ack(0, 1'b1);
    chk("err state", state_o, S_ER);
    chk("err flag", err, 1);
    chk("err disp", disp_val, 0);
    press_dig(5);
    chk("err sticky", state_o, S_ER);
    press_op(6);
    chk("clr state", state_o, S_EA);
    chk("clr err", err, 0);

    // chaining from a result
    press_dig(6); press_op(1); press_dig(4); press_op(7);
    do_ack(10, 1'b0);
    press_op(2); press_dig(3); press_op(7);
    chk("chain a", $signed(alu_if.alu_a), 10);
    chk("chain b", $signed(alu_if.alu_b), 3);
    chk("chain op", alu_if.alu_op, 1);
    do_ack(7, 1'b0);

    // same-cycle priority, deferred clear
    press_op(6); press_dig(1); press_op(3);
    bd[5] = 1'b1; bo[1] = 1'b1; tick(); bd[5] = 1'b0; bo[1] = 1'b0; tick();
    chk("prio state", state_o, S_OS);
    chk("prio op", alu_if.alu_op, 0);
    chk("prio disp", disp_val, 1);
    press_dig(2); press_op(7); press_op(6);
    chk("defer state", state_o, S_IS);
    do_ack(42, 1'b0);
    chk("defer after", state_o, S_EA);
    chk("defer disp", disp_val, 0);
    chk("defer req", alu_if.alu_req, 0);

    // asynchronous reset while requesting
    press_dig(1); press_op(1); press_dig(2); press_op(7);
    chk("pre-rst req", alu_if.alu_req, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst req", alu_if.alu_req, 0);
    chk("rst state", state_o, 0);
    chk("rst a", alu_if.alu_a, 0);
    chk("rst b", alu_if.alu_b, 0);
    chk("rst op", alu_if.alu_op, 0);
    chk("rst disp", disp_val, 0);
    chk("rst sel", disp_sel, 0);
    chk("rst err", err, 0);
    repeat (2) tick();
    rst = 1'b0;

    // random traffic
    for (int c = 0; c < 5000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) begin bd = '0; bo = '0; end
      else if (r < 70) begin bd = '0; bo = '0; bd[$urandom_range(0, 9)] = 1'b1; end
      else if (r < 82) begin bd = '0; bo = '0; bo[$urandom_range(0, 5)] = 1'b1; end
      else if (r < 88) begin bd = '0; bo = '0; bo[7] = 1'b1; end
      else if (r < 90) begin bd = '0; bo = '0; bo[6] = 1'b1; end
      else if (r < 95) begin bd[$urandom_range(0, 9)] = 1'b1; bo[$urandom_range(0, 7)] = 1'b1; end
      if ((m_st == S_IS && $urandom_range(0, 2) == 0) || $urandom_range(0, 30) == 0) begin
        ack  = 1'b1;
        ares = 32'(int'($urandom_range(0, 200000)) - 100000);
        aerr = ($urandom_range(0, 7) == 0);
      end else begin
        ack = 1'b0; aerr = 1'b0;
      end
      tick();
    end
    ack = 1'b0; bd = '0; bo = '0;
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
